// File: rtl/sdram_boot_mux.sv
// SDRAM request-port owner: copies the boot image from ROM into SDRAM,
// then turns CPU request pulses into held level requests.
module sdram_boot_mux #(
  parameter int          ROM_AW    = 8,
  parameter int          ROM_WORDS = 256,
  parameter int          ROM_LAT   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dram_init,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_size,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  output logic              cpu_valid,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_size,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic              mem_rd_valid,
  input  logic              mem_wr_valid,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } state_t;

  localparam logic [2:0]        LAT  = 3'(ROM_LAT);
  localparam logic [ROM_AW-1:0] LAST = ROM_AW'(ROM_WORDS - 1);

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [ROM_AW-1:0] idx_n;
  logic [31:0]       wdata, wdata_n;
  logic              rd_n, wr_n, done_n, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rom_addr   <= '0;
      wdata      <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rom_addr   <= idx_n;
      wdata      <= wdata_n;
      mem_rd_req <= rd_n;
      mem_wr_req <= wr_n;
      boot_done  <= done_n;
      boot_err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = rom_addr;
    wdata_n = wdata;
    rd_n    = mem_rd_req;
    wr_n    = mem_wr_req;
    done_n  = boot_done;
    err_n   = boot_err;
    unique case (state)
      IDLE: begin
        if (dram_init) begin
          state_n = FETCH;
          cnt_n   = LAT;
        end
      end
      FETCH: begin
        if (cnt <= 3'd1) begin
          cnt_n   = '0;
          wdata_n = rom_data;
          wr_n    = 1'b1;
          state_n = WRITE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      WRITE: begin
        if (mem_wr_valid) begin
          wr_n = 1'b0;
          if (rom_addr == LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n   = rom_addr + ROM_AW'(1);
            cnt_n   = LAT;
            state_n = FETCH;
          end
        end
      end
      DONE: begin
        // a completion cycle never starts a new request
        if (mem_rd_valid || mem_wr_valid) begin
          if (mem_rd_valid) rd_n = 1'b0;
          if (mem_wr_valid) wr_n = 1'b0;
        end else begin
          if (cpu_rd_req) rd_n = 1'b1;
          if (cpu_wr_req) wr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!boot_done && (cpu_rd_req || cpu_wr_req)) err_n = 1'b1;
  end

  assign mem_addr  = boot_done ? cpu_addr
                   : BASE_ADDR + (32'(rom_addr) << 2);
  assign mem_wdata = boot_done ? cpu_wdata : wdata;
  assign mem_size  = boot_done ? cpu_size : 3'b010;
  assign cpu_valid = (mem_rd_valid | mem_wr_valid) & boot_done;

endmodule

// File: tb/tb_sdram_boot_mux.sv
// Bench for sdram_boot_mux: transaction-timing model checked every
// cycle, plus directed boot/reset/CPU scenarios with literal values.
module tb_sdram_boot_mux;

  localparam int          AW   = 8;
  localparam int          N    = 4;
  localparam int          LAT  = 1;
  localparam logic [31:0] BASE = 32'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dram_init = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [2:0]    cpu_size = '0;
  logic          cpu_rd_req = 1'b0;
  logic          cpu_wr_req = 1'b0;
  logic          cpu_valid;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mem_size;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic          mem_rd_valid = 1'b0;
  logic          mem_wr_valid = 1'b0;
  logic          boot_done;
  logic          boot_err;

  logic [31:0] rom [0:(1<<AW)-1];
  int          total = 0;
  int          passed = 0;
  bit          auto_ack = 1'b1;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  sdram_boot_mux #(
    .ROM_AW(AW), .ROM_WORDS(N), .ROM_LAT(LAT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .dram_init(dram_init),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_rd_req(cpu_rd_req),
    .cpu_wr_req(cpu_wr_req), .cpu_valid(cpu_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_rd_valid(mem_rd_valid),
    .mem_wr_valid(mem_wr_valid), .boot_done(boot_done),
    .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 32'hA0 + i;
  end

  // SDRAM write responder used during boot: ack on the 3rd cycle of a request
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (auto_ack) begin
        mem_wr_valid = 1'b0;
        if (mem_wr_req) begin
          wcnt++;
          if (wcnt == 3) begin
            mem_wr_valid = 1'b1;
            wcnt = 0;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Model: word k's write request is due LAT+1 edges after boot start
  // or after word k-1 completes; done after N completions.
  initial begin
    int  cyc, m_k, m_due;
    bit  m_done, m_err, m_started, m_rd, m_wr, exp_wr, was_done;
    cyc = 0; m_k = 0; m_due = 0;
    m_done = 0; m_err = 0; m_started = 0; m_rd = 0; m_wr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_done = 0; m_err = 0; m_started = 0;
        m_k = 0; m_rd = 0; m_wr = 0;
        wq_addr.delete();
        wq_data.delete();
        check("rst_rom_addr", rom_addr, 0);
        check("rst_wr_req", mem_wr_req, 0);
        check("rst_rd_req", mem_rd_req, 0);
        check("rst_done", boot_done, 0);
        check("rst_err", boot_err, 0);
        check("rst_cpu_valid", cpu_valid, 0);
      end else begin
        exp_wr = m_done ? m_wr : (m_started && cyc >= m_due);
        check("boot_done", boot_done, m_done);
        check("boot_err", boot_err, m_err);
        check("wr_req", mem_wr_req, exp_wr);
        check("rom_addr", rom_addr, (m_k < N) ? m_k : N - 1);
        if (!m_done) begin
          check("boot_rd_req", mem_rd_req, 0);
          check("boot_cpu_valid", cpu_valid, 0);
          if (exp_wr) begin
            check("boot_addr", mem_addr, BASE + 32'(m_k) * 4);
            check("boot_wdata", mem_wdata, rom[m_k]);
            check("boot_size", mem_size, 3'b010);
          end
        end else begin
          check("rd_req", mem_rd_req, m_rd);
          check("cpu_valid", cpu_valid, mem_rd_valid | mem_wr_valid);
          check("pass_addr", mem_addr, cpu_addr);
          check("pass_wdata", mem_wdata, cpu_wdata);
          check("pass_size", mem_size, cpu_size);
        end
        was_done = m_done;
        if (!was_done && (cpu_rd_req || cpu_wr_req)) m_err = 1;
        if (!m_started && dram_init) begin
          m_started = 1;
          m_due = cyc + 1 + LAT;
        end else if (!was_done && exp_wr && mem_wr_valid) begin
          wq_addr.push_back(mem_addr);
          wq_data.push_back(mem_wdata);
          m_k++;
          if (m_k == N) m_done = 1;
          else m_due = cyc + 1 + LAT;
        end
        if (was_done) begin
          if (mem_rd_valid || mem_wr_valid) begin
            if (mem_rd_valid) m_rd = 0;
            if (mem_wr_valid) m_wr = 0;
          end else begin
            if (cpu_rd_req) m_rd = 1;
            if (cpu_wr_req) m_wr = 1;
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (50) @(negedge clk);
    check("idle_rom_addr", rom_addr, 0);
    check("idle_no_wr", mem_wr_req, 0);
    @(posedge clk); #1 dram_init = 1'b1;

    n = 0;
    while (!(mem_wr_req && rom_addr == 2) && n < 100) begin
      @(negedge clk); n++;
    end
    check("reach_word2", n < 100, 1);
    check("w2_addr", mem_addr, 32'h8);
    check("w2_data", mem_wdata, 32'hA2);

    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("async_rom_addr", rom_addr, 0);
    check("async_wr_req", mem_wr_req, 0);
    check("async_done", boot_done, 0);
    check("async_rd_req", mem_rd_req, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    n = 0;
    while (!mem_wr_req && n < 20) begin
      @(negedge clk); n++;
    end
    check("restart_seen", n < 20, 1);
    check("restart_addr", mem_addr, 32'h0);
    check("restart_data", mem_wdata, 32'hA0);

    n = 0;
    while (rom_addr != 1 && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1 dram_init = 1'b0;

    n = 0;
    while (rom_addr != 2 && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1 cpu_rd_req = 1'b1;
    @(posedge clk); #1 cpu_rd_req = 1'b0;
    @(negedge clk);
    check("err_set", boot_err, 1);
    check("err_dropped", mem_rd_req, 0);

    n = 0;
    while (!boot_done && n < 200) begin
      @(negedge clk); n++;
    end
    check("boot_finished", boot_done, 1);
    check("write_count", wq_addr.size(), 4);
    if (wq_addr.size() == 4) begin
      check("wq_addr0", wq_addr[0], 32'h0);
      check("wq_addr1", wq_addr[1], 32'h4);
      check("wq_addr2", wq_addr[2], 32'h8);
      check("wq_addr3", wq_addr[3], 32'hC);
      check("wq_data0", wq_data[0], 32'hA0);
      check("wq_data3", wq_data[3], 32'hA3);
    end
    check("err_sticky", boot_err, 1);
    auto_ack = 1'b0;
    mem_wr_valid = 1'b0;

    @(posedge clk);
    #1 cpu_addr = 32'h100; cpu_size = 3'b010; cpu_rd_req = 1'b1;
    @(negedge clk);
    check("rd_not_yet", mem_rd_req, 0);
    @(posedge clk); #1 cpu_rd_req = 1'b0;
    @(negedge clk);
    check("rd_rise", mem_rd_req, 1);
    check("rd_addr", mem_addr, 32'h100);
    repeat (4) @(posedge clk);
    #1 mem_rd_valid = 1'b1;
    @(negedge clk);
    check("rd_cpu_valid", cpu_valid, 1);
    check("rd_held", mem_rd_req, 1);
    @(posedge clk); #1 mem_rd_valid = 1'b0;
    @(negedge clk);
    check("rd_cleared", mem_rd_req, 0);
    check("rd_valid_single", cpu_valid, 0);

    @(posedge clk);
    #1 cpu_addr = 32'h200; cpu_wdata = 32'hDEADBEEF;
    cpu_wr_req = 1'b1;
    @(posedge clk); #1 cpu_wr_req = 1'b0;
    @(negedge clk);
    check("wr_rise", mem_wr_req, 1);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1 mem_wr_valid = 1'b1; cpu_rd_req = 1'b1;
    @(negedge clk);
    check("wr_cpu_valid", cpu_valid, 1);
    @(posedge clk); #1 mem_wr_valid = 1'b0; cpu_rd_req = 1'b0;
    @(negedge clk);
    check("wr_cleared", mem_wr_req, 0);
    check("rd_blocked", mem_rd_req, 0);
    @(negedge clk);
    check("rd_still_low", mem_rd_req, 0);

    @(posedge clk); #1 cpu_rd_req = 1'b1; cpu_wr_req = 1'b1;
    @(posedge clk); #1 cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
    @(negedge clk);
    check("both_rd", mem_rd_req, 1);
    check("both_wr", mem_wr_req, 1);
    @(posedge clk); #1 mem_rd_valid = 1'b1;
    @(posedge clk); #1 mem_rd_valid = 1'b0;
    @(negedge clk);
    check("both_rd_done", mem_rd_req, 0);
    check("both_wr_held", mem_wr_req, 1);
    @(posedge clk); #1 mem_wr_valid = 1'b1;
    @(posedge clk); #1 mem_wr_valid = 1'b0;
    @(negedge clk);
    check("both_wr_done", mem_wr_req, 0);
    check("err_end", boot_err, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
